led_scan_controller: RTL and testbench



---
 rtl/led_scan_pkg.sv | 11 +
 rtl/led_frame_buffer.sv | 36 +++
 rtl/led_scan_controller.sv | 120 ++++++++++++
 tb/tb_led_scan_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared state encoding and counter sizing for the LED column scanner
package led_scan_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    // One shared counter must hold the larger of the dwell and blanking terminal values
    function automatic int cnt_width(input int dwell, input int blank);
        return $clog2(((dwell > blank) ? dwell : blank) + 1);
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: pending/active frame double buffer with valid/ready intake and swap strobe
module led_frame_buffer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cells_in,
    input  logic         cells_valid,
    output logic         cells_ready,
    input  logic         swap,
    output logic [W-1:0] cells
);

    logic [W-1:0] r_pend;
    logic [W-1:0] r_cells;
    logic         r_ready;

    assign cells_ready = r_ready;
    assign cells       = r_cells;

    // Swap only moves a held frame; intake only happens while empty, so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_cells <= '0;
            r_ready <= 1'b1;
        end else if (swap && !r_ready) begin
            r_cells <= r_pend;
            r_ready <= 1'b1;
        end else if (cells_valid && r_ready) begin
            r_pend  <= cells_in;
            r_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column scan sequencer with blanking and frame-boundary double buffering
// Optional PWM brightness on the driver enable when LED_SCAN_BRIGHTNESS_EN is defined.
module led_scan_controller
    import led_scan_pkg::*;
#(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [$clog2(DWELL_CYCLES+1)-1:0] brightness,
`endif
    input  logic [N*N-1:0]         cells_in,
    input  logic                   cells_valid,
    output logic                   cells_ready,
    output logic [$clog2(N):0]     x,
    output logic                   ena,
    output logic [N*N-1:0]         cells,
    output logic                   frame_done
);

    localparam int             CW    = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int             XW    = $clog2(N) + 1;
    localparam logic [CW-1:0]  DLAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]  BLAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [XW-1:0]  XLAST = XW'(N - 1);

    if (N < 1 || N > 8) $error("led_scan_controller: N must be in 1..8");
    if (DWELL_CYCLES < 1) $error("led_scan_controller: DWELL_CYCLES must be >= 1");

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [XW-1:0] r_x;
    logic          r_ena;
    logic          r_frame_done;
    logic          w_last;
    logic          w_swap;
    logic          w_on_first;
    logic          w_on_next;

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [CW:0]   w_cnt_inc;
    assign w_cnt_inc  = {1'b0, r_cnt} + (CW+1)'(1);
    assign w_on_first = (brightness != '0);
    assign w_on_next  = (w_cnt_inc < (CW+1)'(brightness));
`else
    assign w_on_first = 1'b1;
    assign w_on_next  = 1'b1;
`endif

    assign w_last     = enable && (r_state == DRIVE) && (r_cnt == DLAST) && (r_x == XLAST);
    assign w_swap     = w_last || (r_state == IDLE);
    assign x          = r_x;
    assign ena        = r_ena;
    assign frame_done = r_frame_done;

    // ena is registered one step ahead, so it is derived from the counter value being loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_ena        <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_ena        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_frame_done <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    r_ena        <= (BLANK_CYCLES == 0) ? w_on_first : 1'b0;
                end
                BLANK: begin
                    r_frame_done <= 1'b0;
                    if (r_cnt == BLAST) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                        r_ena   <= w_on_first;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_ena   <= 1'b0;
                    end
                end
                default: begin
                    if (r_cnt == DLAST) begin
                        r_cnt        <= '0;
                        r_x          <= (r_x == XLAST) ? '0 : r_x + XW'(1);
                        r_frame_done <= (r_x == XLAST);
                        r_state      <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                        r_ena        <= (BLANK_CYCLES == 0) ? w_on_first : 1'b0;
                    end else begin
                        r_cnt        <= r_cnt + CW'(1);
                        r_ena        <= w_on_next;
                        r_frame_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    led_frame_buffer #(.W(N*N)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .cells_in    (cells_in),
        .cells_valid (cells_valid),
        .cells_ready (cells_ready),
        .swap        (w_swap),
        .cells       (cells)
    );

endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed checks of scan timing, frame handover, back-pressure, enable drop and async reset
module tb_led_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [24:0] cells_in = '0;
    logic        cells_valid = 1'b0;
    logic        cells_ready;
    logic [3:0]  x;
    logic        ena;
    logic [24:0] cells;
    logic        frame_done;
    logic        cells_ready1;
    logic [3:0]  x1;
    logic        ena1;
    logic [24:0] cells1;
    logic        frame_done1;
    int          n_tests = 0;
    int          n_fail = 0;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]  br0 = 3'd4;
    logic [2:0]  br1 = 3'd2;
`endif

    always #5 clk = ~clk;

    led_scan_controller #(.N(5), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness  (br0),
`endif
        .cells_in    (cells_in),
        .cells_valid (cells_valid),
        .cells_ready (cells_ready),
        .x           (x),
        .ena         (ena),
        .cells       (cells),
        .frame_done  (frame_done)
    );

    led_scan_controller #(.N(5), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_nb (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness  (br1),
`endif
        .cells_in    (25'd0),
        .cells_valid (1'b0),
        .cells_ready (cells_ready1),
        .x           (x1),
        .ena         (ena1),
        .cells       (cells1),
        .frame_done  (frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".x"}, 32'(x), 0);
        check({tag, ".ena"}, 32'(ena), 0);
        check({tag, ".cells"}, 32'(cells), 0);
        check({tag, ".fd"}, 32'(frame_done), 0);
        check({tag, ".ready"}, 32'(cells_ready), 1);
    endtask

    initial begin
        run(2);
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();
        check_reset_vals("idle");

        // scan timing: main DUT 25-cycle frame, no-blank DUT 20-cycle frame
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            int p, q;
            step();
            p = (k - 1) % 25;
            q = k - 1;
            check($sformatf("scan.x k%0d", k), 32'(x), 32'(p / 5));
            check($sformatf("scan.ena k%0d", k), 32'(ena), 32'(p % 5 != 0));
            check($sformatf("scan.fd k%0d", k), 32'(frame_done), 32'(k > 1 && p == 0));
            check($sformatf("nb.x k%0d", k), 32'(x1), 32'((q / 4) % 5));
`ifdef LED_SCAN_BRIGHTNESS_EN
            check($sformatf("nb.ena k%0d", k), 32'(ena1), 32'((q % 4) < 2));
`else
            check($sformatf("nb.ena k%0d", k), 32'(ena1), 1);
`endif
            check($sformatf("nb.fd k%0d", k), 32'(frame_done1), 32'(k > 1 && q % 20 == 0));
        end

        // handover of 0x1F mid-frame
        cells_valid = 1'b1;
        cells_in = 25'h1F;
        step();
        check("ho.ready_drop", 32'(cells_ready), 0);
        check("ho.cells_old", 32'(cells), 0);
        cells_valid = 1'b0;
        run(19);
        check("ho.cells_hold", 32'(cells), 0);
        check("ho.fd_before", 32'(frame_done), 0);
        step();
        check("ho.fd", 32'(frame_done), 1);
        check("ho.cells_new", 32'(cells), 32'h1F);
        check("ho.ready_back", 32'(cells_ready), 1);

        // back-pressure: 0xAA fills pending, 0x155 waits
        cells_valid = 1'b1;
        cells_in = 25'hAA;
        step();
        check("bp.full", 32'(cells_ready), 0);
        cells_in = 25'h155;
        run(23);
        check("bp.stall", 32'(cells_ready), 0);
        check("bp.cells_1f", 32'(cells), 32'h1F);
        step();
        check("bp.fd", 32'(frame_done), 1);
        check("bp.cells_aa", 32'(cells), 32'hAA);
        check("bp.ready_free", 32'(cells_ready), 1);
        step();
        check("bp.accept", 32'(cells_ready), 0);
        check("bp.cells_aa2", 32'(cells), 32'hAA);
        cells_valid = 1'b0;
        run(24);
        check("bp.fd2", 32'(frame_done), 1);
        check("bp.cells_155", 32'(cells), 32'h155);
        check("bp.ready2", 32'(cells_ready), 1);

        // enable drop at x=2 mid-DRIVE
        run(11);
        check("en.x2", 32'(x), 2);
        check("en.ena2", 32'(ena), 1);
        enable = 1'b0;
        step();
        check("en.off_ena", 32'(ena), 0);
        check("en.off_x", 32'(x), 0);
        check("en.off_fd", 32'(frame_done), 0);
        run(2);
        cells_valid = 1'b1;
        cells_in = 25'h3;
        step();
        check("idle.load", 32'(cells_ready), 0);
        check("idle.cells_old", 32'(cells), 32'h155);
        cells_valid = 1'b0;
        step();
        check("idle.swap", 32'(cells), 32'h3);
        check("idle.ready", 32'(cells_ready), 1);
        for (int i = 0; i < 15; i++) begin
            step();
            check($sformatf("idle.fd %0d", i), 32'(frame_done), 0);
        end
        enable = 1'b1;
        step();
        check("re.blank_x", 32'(x), 0);
        check("re.blank_ena", 32'(ena), 0);
        step();
        check("re.drive_ena", 32'(ena), 1);
        check("re.drive_x", 32'(x), 0);
        run(3);
        check("re.dwell_end", 32'(ena), 1);
        step();
        check("re.blank1_ena", 32'(ena), 0);
        check("re.blank1_x", 32'(x), 1);
        step();
        check("re.drive1", 32'(ena), 1);

        // async reset mid-DRIVE with pending full
        cells_valid = 1'b1;
        cells_in = 25'h7;
        step();
        check("ar.full", 32'(cells_ready), 0);
        cells_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("ar");
        enable = 1'b0;
        #2 rst_n = 1'b1;
        run(2);
        check("ar.lost_cells", 32'(cells), 0);
        check("ar.lost_ready", 32'(cells_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
